// File: rtl/lpc_defines.sv
// Shared definitions for the LPC peripheral target: cycle codes, SYNC codes, FSM states.
package lpc_defines;

  localparam logic [3:0] LPC_START  = 4'b0000;

  // Cycle type as carried on LAD[3:1] in the nibble after START
  localparam logic [2:0] CYC_IO_RD  = 3'b000;
  localparam logic [2:0] CYC_IO_WR  = 3'b001;
  localparam logic [2:0] CYC_MEM_RD = 3'b010;
  localparam logic [2:0] CYC_MEM_WR = 3'b011;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    StIdle,
    StStart,
    StAddr,
    StWdata,
    StTar1,
    StTar2,
    StSync,
    StRdata1,
    StRdata2,
    StPtar1,
    StPtar2,
    StIgnore
  } lpc_state_e;

  // States in which the target owns LAD
  function automatic logic lad_driven(lpc_state_e s);
    return (s == StSync) || (s == StRdata1) || (s == StRdata2) || (s == StPtar1);
  endfunction

endpackage

// File: rtl/lpc_sync_ctrl.sv
// SYNC nibble generation: latches the back-end answer, counts long-wait nibbles and
// flags the timeout.
module lpc_sync_ctrl
  import lpc_defines::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       clr_i,     // new cycle framing: forget the previous answer
  input  logic       sel_i,     // a SYNC nibble is being issued at this edge
  input  logic       req_i,     // back-end request currently outstanding
  input  logic       ack_i,
  input  logic       err_i,
  input  logic [7:0] rdata_i,
  output logic [3:0] nib_o,
  output logic       done_o,    // final (ready/error) nibble already issued
  output logic       tmo_o,
  output logic [7:0] rdata_o
);

  localparam int unsigned CntW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SYNC_TIMEOUT);

  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic ack_now, ack_seen, err_seen, at_max;

  // An ack sampled on this very edge already counts, so a zero-wait answer gives READY first
  assign ack_now  = req_i & ack_i;
  assign ack_seen = ack_q | ack_now;
  assign err_seen = ack_q ? err_q : err_i;
  assign at_max   = (cnt_q == CntMax);

  assign tmo_o   = sel_i & ~ack_seen & at_max;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;

  // SYNC nibble selection
  always_comb begin
    nib_o = SYNC_LWAIT;
    if (ack_seen) begin
      nib_o = err_seen ? SYNC_ERR : SYNC_READY;
    end else if (at_max) begin
      nib_o = SYNC_ERR;
    end
  end

  // Ack latch and wait counter next state
  always_comb begin
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (clr_i) begin
      ack_d  = 1'b0;
      err_d  = 1'b0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      if (ack_now) begin
        ack_d   = 1'b1;
        err_d   = err_i;
        rdata_d = rdata_i;
      end
      if (sel_i) begin
        if (ack_seen) begin
          done_d = 1'b1;
        end else if (at_max) begin
          done_d  = 1'b1;
          rdata_d = 8'hFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/lpc_periph_io.sv
// LPC peripheral target with req/ack back-end. Optional memory cycles: LPC_MEM_CYCLES_EN.
module lpc_periph_io
  import lpc_defines::*;
#(
  parameter logic [15:0] DEC_BASE     = 16'h0080,
  parameter logic [15:0] DEC_MASK     = 16'hFFFF,
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter logic [31:0] MEM_BASE     = 32'hFED4_0000,
  parameter logic [31:0] MEM_MASK     = 32'hFFFF_F000
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  output logic        per_req_o,
  output logic        per_wr_o,
  output logic        per_mem_o,
  output logic [31:0] per_addr_o,
  output logic [7:0]  per_wdata_o,
  input  logic [7:0]  per_rdata_i,
  input  logic        per_ack_i,
  input  logic        per_err_i,
  output logic        busy_o
);

  lpc_state_e  state_q, state_d;
  logic [2:0]  nib_q, nib_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        req_q, req_d;
  logic [3:0]  lad_q, lad_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;

`ifdef LPC_MEM_CYCLES_EN
  logic mem_q, mem_d;
`else
  logic mem_q;
  assign mem_q = 1'b0;
`endif

  logic [3:0]  sync_nib;
  logic        sync_done, sync_tmo;
  logic [7:0]  sync_rdata;
  logic [15:0] io_addr;
  logic [31:0] mem_addr;
  logic        hit;

  // Address including the nibble on LAD now, for the decision on the last ADDR nibble
  assign io_addr  = {addr_q[11:0], lad_i};
  assign mem_addr = {addr_q[27:0], lad_i};
  assign hit      = mem_q ? ((mem_addr & MEM_MASK) == MEM_BASE)
                          : ((io_addr & DEC_MASK) == DEC_BASE);

  lpc_sync_ctrl #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) u_sync (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .clr_i   (~lframe_i),
    .sel_i   (state_d == StSync),
    .req_i   (req_q),
    .ack_i   (per_ack_i),
    .err_i   (per_err_i),
    .rdata_i (per_rdata_i),
    .nib_o   (sync_nib),
    .done_o  (sync_done),
    .tmo_o   (sync_tmo),
    .rdata_o (sync_rdata)
  );

  // Cycle decode FSM; LFRAME# low overrides every state
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LPC_MEM_CYCLES_EN
    mem_d   = mem_q;
`endif
    if (!lframe_i) begin
      state_d = (lad_i == LPC_START) ? StStart : StIdle;
    end else begin
      case (state_q)
        StStart: begin
          nib_d  = '0;
          addr_d = '0;
          if (lad_i[3:1] == CYC_IO_RD || lad_i[3:1] == CYC_IO_WR) begin
            state_d = StAddr;
            wr_d    = lad_i[1];
`ifdef LPC_MEM_CYCLES_EN
            mem_d   = 1'b0;
          end else if (lad_i[3:1] == CYC_MEM_RD || lad_i[3:1] == CYC_MEM_WR) begin
            state_d = StAddr;
            wr_d    = lad_i[1];
            mem_d   = 1'b1;
`else
          end else if (lad_i[3:1] == CYC_MEM_RD || lad_i[3:1] == CYC_MEM_WR) begin
            // memory cycles are not claimed in this build
            state_d = StIgnore;
`endif
          end else begin
            state_d = StIgnore;
          end
        end
        StAddr: begin
          addr_d = {addr_q[27:0], lad_i};
          nib_d  = nib_q + 3'd1;
          if (nib_q == (mem_q ? 3'd7 : 3'd3)) begin
            nib_d = '0;
            if (!hit)      state_d = StIgnore;
            else if (wr_q) state_d = StWdata;
            else           state_d = StTar1;
          end
        end
        StWdata: begin
          if (nib_q == 3'd0) begin
            wdata_d = {wdata_q[7:4], lad_i};
            nib_d   = 3'd1;
          end else begin
            wdata_d = {lad_i, wdata_q[3:0]};
            state_d = StTar1;
          end
        end
        StTar1:   state_d = StTar2;
        StTar2:   state_d = StSync;
        StSync:   if (sync_done) state_d = wr_q ? StPtar1 : StRdata1;
        StRdata1: state_d = StRdata2;
        StRdata2: state_d = StPtar1;
        StPtar1:  state_d = StPtar2;
        StPtar2:  state_d = StIdle;
        StIdle, StIgnore: state_d = state_q;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Registered outputs derived from the next state
  always_comb begin
    req_d = req_q;
    if (!lframe_i) begin
      req_d = 1'b0;
    end else if (state_d == StTar1 && state_q != StTar1) begin
      req_d = 1'b1;
    end else if ((req_q && per_ack_i) || sync_tmo) begin
      req_d = 1'b0;
    end

    lad_d = 4'hF;
    case (state_d)
      StSync:   lad_d = sync_nib;
      StRdata1: lad_d = sync_rdata[3:0];
      StRdata2: lad_d = sync_rdata[7:4];
      default:  lad_d = 4'hF;
    endcase

    oe_d   = lad_driven(state_d);
    busy_d = (state_d != StIdle) && (state_d != StIgnore);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= StIdle;
      nib_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      lad_q   <= 4'hF;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      lad_q   <= lad_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LPC_MEM_CYCLES_EN
  // Memory-cycle flag
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) mem_q <= 1'b0;
    else         mem_q <= mem_d;
  end
`endif

  assign lad_o       = lad_q;
  assign lad_oe_o    = oe_q;
  assign per_req_o   = req_q;
  assign per_wr_o    = wr_q;
  assign per_mem_o   = mem_q;
  assign per_addr_o  = addr_q;
  assign per_wdata_o = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_lpc_periph_io.sv
// Directed bench for lpc_periph_io with default parameters.
module tb_lpc_periph_io;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        lframe_i;
  logic [3:0]  lad_i;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic        per_req_o;
  logic        per_wr_o;
  logic        per_mem_o;
  logic [31:0] per_addr_o;
  logic [7:0]  per_wdata_o;
  logic [7:0]  per_rdata_i;
  logic        per_ack_i;
  logic        per_err_i;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  lpc_periph_io dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .lframe_i    (lframe_i),
    .lad_i       (lad_i),
    .lad_o       (lad_o),
    .lad_oe_o    (lad_oe_o),
    .per_req_o   (per_req_o),
    .per_wr_o    (per_wr_o),
    .per_mem_o   (per_mem_o),
    .per_addr_o  (per_addr_o),
    .per_wdata_o (per_wdata_o),
    .per_rdata_i (per_rdata_i),
    .per_ack_i   (per_ack_i),
    .per_err_i   (per_err_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one LPC clock, then sample 1 time unit after the edge
  task automatic step(input logic lf, input logic [3:0] lad);
    lframe_i = lf;
    lad_i    = lad;
    @(posedge clk_i);
    #1;
  endtask

  // START, cycle type, then n address nibbles MSB first
  task automatic hdr(input logic [3:0] cyc, input logic [31:0] a, input int n);
    step(1'b0, 4'h0);
    step(1'b1, cyc);
    for (int i = n - 1; i >= 0; i--) step(1'b1, a[4*i +: 4]);
  endtask

  initial begin
    nrst_i = 1'b0; lframe_i = 1'b1; lad_i = 4'hF;
    per_ack_i = 1'b0; per_err_i = 1'b0; per_rdata_i = 8'h00;
    #12;
    chk("rst_oe", lad_oe_o, 0);
    chk("rst_lad", lad_o, 4'hF);
    chk("rst_req", per_req_o, 0);
    chk("rst_wr", per_wr_o, 0);
    chk("rst_mem", per_mem_o, 0);
    chk("rst_addr", per_addr_o, 0);
    chk("rst_wdata", per_wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    nrst_i = 1'b1;
    step(1'b1, 4'hF);
    chk("idle_busy", busy_o, 0);

    // I/O write 0x0080 <= 0xA5, ack after two long-wait nibbles
    hdr(4'b0010, 32'h0080, 4);
    chk("w_addr", per_addr_o, 32'h0000_0080);
    chk("w_busy", busy_o, 1);
    step(1'b1, 4'h5);
    step(1'b1, 4'hA);
    chk("w_req", per_req_o, 1);
    chk("w_wr", per_wr_o, 1);
    chk("w_wdata", per_wdata_o, 8'hA5);
    chk("w_tar1_oe", lad_oe_o, 0);
    step(1'b1, 4'hF);
    chk("w_tar2_oe", lad_oe_o, 0);
    step(1'b1, 4'hF);
    chk("w_sync0", lad_o, 4'h6);
    chk("w_sync0_oe", lad_oe_o, 1);
    step(1'b1, 4'hF);
    chk("w_sync1", lad_o, 4'h6);
    per_ack_i = 1'b1;
    step(1'b1, 4'hF);
    per_ack_i = 1'b0;
    chk("w_ready", lad_o, 4'h0);
    chk("w_req_fall", per_req_o, 0);
    step(1'b1, 4'hF);
    chk("w_ptar1", lad_o, 4'hF);
    chk("w_ptar1_oe", lad_oe_o, 1);
    step(1'b1, 4'hF);
    chk("w_ptar2_oe", lad_oe_o, 0);
    step(1'b1, 4'hF);
    chk("w_idle_busy", busy_o, 0);

    // I/O read 0x0080, ack during TAR1 with 0x3C
    hdr(4'b0000, 32'h0080, 4);
    chk("r_req", per_req_o, 1);
    chk("r_wr", per_wr_o, 0);
    per_ack_i = 1'b1; per_rdata_i = 8'h3C;
    step(1'b1, 4'hF);
    per_ack_i = 1'b0; per_rdata_i = 8'h00;
    chk("r_req_fall", per_req_o, 0);
    step(1'b1, 4'hF);
    chk("r_sync", lad_o, 4'h0);
    chk("r_sync_oe", lad_oe_o, 1);
    step(1'b1, 4'hF);
    chk("r_data_lo", lad_o, 4'hC);
    step(1'b1, 4'hF);
    chk("r_data_hi", lad_o, 4'h3);
    step(1'b1, 4'hF);
    chk("r_ptar", lad_o, 4'hF);
    chk("r_ptar_oe", lad_oe_o, 1);
    step(1'b1, 4'hF);
    chk("r_ptar2_oe", lad_oe_o, 0);

    // Read 0x0081 misses the window
    hdr(4'b0000, 32'h0081, 4);
    chk("miss_busy", busy_o, 0);
    chk("miss_addr", per_addr_o, 32'h0000_0081);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF);
      chk("miss_oe", lad_oe_o, 0);
      chk("miss_req", per_req_o, 0);
    end

    // Read with no ack: 8 long waits, error, 0xFF data, late ack dropped
    hdr(4'b0000, 32'h0080, 4);
    step(1'b1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'hF);
      chk("to_lwait", lad_o, 4'h6);
      chk("to_req_hold", per_req_o, 1);
    end
    step(1'b1, 4'hF);
    chk("to_err", lad_o, 4'hA);
    chk("to_req_fall", per_req_o, 0);
    per_ack_i = 1'b1; per_rdata_i = 8'h12;
    step(1'b1, 4'hF);
    chk("to_data_lo", lad_o, 4'hF);
    chk("to_late_req", per_req_o, 0);
    step(1'b1, 4'hF);
    chk("to_data_hi", lad_o, 4'hF);
    per_ack_i = 1'b0; per_rdata_i = 8'h00;
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    chk("to_idle_busy", busy_o, 0);

    // Abort during SYNC wait, then a write answered with error in TAR2
    hdr(4'b0000, 32'h0080, 4);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    chk("ab_wait", lad_o, 4'h6);
    step(1'b0, 4'h0);
    chk("ab_oe", lad_oe_o, 0);
    chk("ab_req", per_req_o, 0);
    chk("ab_busy", busy_o, 1);
    step(1'b1, 4'b0010);
    for (int i = 3; i >= 0; i--) begin
      logic [15:0] a;
      a = 16'h0080;
      step(1'b1, a[4*i +: 4]);
    end
    step(1'b1, 4'hA);
    step(1'b1, 4'h5);
    chk("ab2_wdata", per_wdata_o, 8'h5A);
    chk("ab2_req", per_req_o, 1);
    step(1'b1, 4'hF);
    per_ack_i = 1'b1; per_err_i = 1'b1;
    step(1'b1, 4'hF);
    per_ack_i = 1'b0; per_err_i = 1'b0;
    chk("ab2_errsync", lad_o, 4'hA);
    chk("ab2_req_fall", per_req_o, 0);
    step(1'b1, 4'hF);
    chk("ab2_ptar", lad_o, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);

    // Asynchronous reset in the middle of RDATA
    hdr(4'b0000, 32'h0080, 4);
    per_ack_i = 1'b1; per_rdata_i = 8'h96;
    step(1'b1, 4'hF);
    per_ack_i = 1'b0;
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    chk("ar_rdata1", lad_o, 4'h6);
    #2 nrst_i = 1'b0;
    #1;
    chk("ar_oe", lad_oe_o, 0);
    chk("ar_lad", lad_o, 4'hF);
    chk("ar_addr", per_addr_o, 0);
    chk("ar_busy", busy_o, 0);
    @(negedge clk_i);
    nrst_i = 1'b1;
    step(1'b1, 4'hF);
    chk("ar_idle_oe", lad_oe_o, 0);

`ifdef LPC_MEM_CYCLES_EN
    // Memory write to 0xFED40010
    hdr(4'b0110, 32'hFED4_0010, 8);
    chk("mem_flag", per_mem_o, 1);
    chk("mem_addr", per_addr_o, 32'hFED4_0010);
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    chk("mem_req", per_req_o, 1);
    step(1'b0, 4'hF);
    chk("mem_abort_req", per_req_o, 0);
`else
    // Memory read type is not claimed
    hdr(4'b0100, 32'hFED4, 4);
    chk("mem_ign_busy", busy_o, 0);
    chk("mem_ign_flag", per_mem_o, 0);
    step(1'b1, 4'hF);
    chk("mem_ign_oe", lad_oe_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lpc_periph_io.md
Name: lpc_periph_io

Overview:
Parametrised LPC peripheral target; next generation of the basic LPC peripheral FSM.
- Decodes LPC I/O read/write cycles against a configurable address window.
- Presents decoded accesses on a simple req/ack back-end bus.
- Inserts long-wait SYNC until the back-end answers, with error SYNC on timeout or back-end error.
- LAD is split into in/out/oe; the top level builds the tri-state.

Parameters:
DEC_BASE, 16'h0080, I/O window base; hit when (addr & DEC_MASK) == DEC_BASE
DEC_MASK, 16'hFFFF, I/O window compare mask
SYNC_TIMEOUT, 8, max long-wait (0110) SYNC clocks before error SYNC; range 1..255
MEM_BASE, 32'hFED4_0000, memory window base (used only with LPC_MEM_CYCLES_EN)
MEM_MASK, 32'hFFFF_F000, memory window mask (used only with LPC_MEM_CYCLES_EN)

Ports:
clk_i  in  1  LPC clock
nrst_i  in  1  reset, asynchronous, active-low
lframe_i  in  1  LFRAME#, active low
lad_i  in  4  LAD sampled value
lad_o  out  4  LAD drive value
lad_oe_o  out  1  LAD output enable
per_req_o  out  1  back-end access request (level)
per_wr_o  out  1  1 = write, 0 = read; valid while per_req_o
per_mem_o  out  1  1 = memory cycle; tied 0 without LPC_MEM_CYCLES_EN
per_addr_o  out  32  captured address; upper 16 bits are 0 for I/O
per_wdata_o  out  8  write data; valid while per_req_o && per_wr_o
per_rdata_i  in  8  read data; sampled on the per_ack_i edge
per_ack_i  in  1  access complete; sampled at rising clk_i while per_req_o
per_err_i  in  1  qualifies per_ack_i; 1 = error SYNC
busy_o  out  1  high in any state other than IDLE/IGNORE

Behaviour:
- Timing: all state and outputs are registered on rising clk_i.
- Reset (async): state IDLE, lad_oe_o=0, lad_o=4'hF, per_req_o=0, per_wr_o=0, per_mem_o=0, per_addr_o=0, per_wdata_o=0, busy_o=0, sync counter 0, ack latch 0.
- Start: lframe_i=0 with lad_i=0000 → START, in any state.
  - This aborts the current transfer: lad_oe_o=0 and per_req_o=0 on the next edge.
  - lframe_i=0 with any other LAD → IDLE.
- START, lframe_i=1, lad_i[3:1]:
  - 000 (I/O read) → ADDR.
  - 001 (I/O write) → ADDR.
  - anything else → IGNORE. IGNORE never drives LAD and is left only by a new START.
- ADDR: 4 nibbles, MSB first, shifted into the address. On the last nibble:
  - miss → IGNORE;
  - hit, read → TAR1;
  - hit, write → WDATA.
- WDATA: 2 nibbles, low nibble first, then TAR1.
- Host turnaround: TAR1 → TAR2 → SYNC. LAD is not driven in either state.
- per_req_o: rises on the edge entering TAR1 and falls on the edge where per_ack_i=1 is sampled. The ack latch records per_ack_i/per_err_i and per_rdata_i.
- SYNC, one nibble per clock:
  - ack latched, err=0 → drive 0000;
  - ack latched, err=1 → drive 1010;
  - counter == SYNC_TIMEOUT → drive 1010 and deassert per_req_o;
  - otherwise → drive 0110 and increment the counter.
  - After the ready/error nibble: read → RDATA1, write → PTAR1.
  - Zero-wait case: ack inside TAR1/TAR2 gives a first SYNC nibble of 0000.
- RDATA1/RDATA2: drive rdata[3:0] then rdata[7:4]. Read data is 8'hFF after a timeout.
- PTAR1: drive 1111. PTAR2: lad_oe_o=0. Then IDLE.
- lad_oe_o is high exactly in SYNC, RDATA1, RDATA2 and PTAR1.
- Back-end acks while per_req_o=0 are ignored. After a timeout, per_req_o stays low and a late ack is dropped.

Optional Feature:
LPC_MEM_CYCLES_EN
- Defined:
  - lad_i[3:1]=010 (memory read) and 011 (memory write) are accepted.
  - ADDR takes 8 nibbles, decoded with MEM_BASE/MEM_MASK.
  - per_mem_o=1 for these cycles.
- Undefined: memory cycles go to IGNORE and per_mem_o is constant 0.

Decomposition:
- Shared package lpc_defines:
  - LPC_START, cycle-type codes;
  - SYNC codes (READY 0000, LWAIT 0110, ERR 1010);
  - state encodings and state width.
- One sub-module, lpc_sync_ctrl, which owns:
  - the ack/err/rdata latch;
  - the timeout counter, sized by $clog2(SYNC_TIMEOUT+1);
  - the SYNC nibble selection.

Test Plan:
- I/O write to 0x0080 with data 0xA5 → per_req_o=1, per_wr_o=1, per_addr_o=0x80, per_wdata_o=0xA5. Ack 2 clocks later → SYNC 0110, 0110, 0000, then PTAR 1111, then release.
- I/O read from 0x0080, ack in TAR1 with rdata 0x3C → SYNC 0000 with no wait, LAD C then 3, PTAR 1111.
- Read from 0x0081 with DEC_MASK=FFFF → IGNORE: lad_oe_o never 1, per_req_o never 1.
- Read with no ack, SYNC_TIMEOUT=8 → exactly 8×0110 then 1010, data FF; a late ack is dropped.
- LFRAME#=0 with LAD=0000 during SYNC wait → lad_oe_o=0, per_req_o=0 next edge, new cycle decoded normally.
- nrst_i low mid-RDATA → all outputs at reset values asynchronously. With LPC_MEM_CYCLES_EN: memory write to 0xFED40010 → per_mem_o=1, per_addr_o=0xFED40010.
